// File: rtl/channel_frame_loader.sv
// channel_frame_loader: collects one streamed R/Y channel frame and presents it in parallel
// until the detector acknowledges it.
module channel_frame_loader #(
  parameter int WL = 16,
  parameter int N = 8,
  localparam int NR = N*(N+1)/2,
  localparam int NW = NR+N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WL-1:0]    in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [NR*WL-1:0] R_out,
  output logic [N*WL-1:0]  Y_out,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             err_len,
  output logic [7:0]       frame_cnt
);
  localparam int CW = $clog2(NW);
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NR*WL-1:0] r_q, r_d;
  logic [N*WL-1:0] y_q, y_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic err_q, err_d, up_q, acc, at_end;
  assign in_ready = up_q && state_q != FULL;
  assign acc = in_valid && in_ready;
  assign at_end = cnt_q == CW'(NW-1);
  assign R_out = r_q;
  assign Y_out = y_q;
  assign frame_valid = state_q == FULL;
  assign err_len = err_q;
  assign frame_cnt = fcnt_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    y_d = y_q;
    fcnt_d = fcnt_q;
    err_d = 1'b0;
    // the overrunning word of a long frame is dropped
    if (acc && !(at_end && !in_last)) begin
      if (cnt_q < CW'(NR)) r_d[32'(cnt_q)*WL +: WL] = in_data;
      else y_d[32'(cnt_q - CW'(NR))*WL +: WL] = in_data;
    end
    if (state_q == FULL) state_d = frame_ack ? IDLE : FULL;
    else if (acc) begin
      state_d = (at_end && in_last) ? FULL : (at_end || in_last) ? IDLE : LOAD;
      cnt_d = (at_end || in_last) ? '0 : cnt_q + 1'b1;
      err_d = at_end != in_last;
      fcnt_d = fcnt_q + {7'd0, at_end && in_last};
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      r_q <= '0;
      y_q <= '0;
      fcnt_q <= '0;
      err_q <= 1'b0;
      up_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      y_q <= y_d;
      fcnt_q <= fcnt_d;
      err_q <= err_d;
      up_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_channel_frame_loader.sv
// tb_channel_frame_loader: scenario tasks driving whole frames and comparing the parallel
// outputs against a matrix/vector model of the frame that was sent.
module tb_channel_frame_loader;
  localparam int WL = 16;
  localparam int N = 8;
  localparam int NR = N*(N+1)/2;
  localparam int NW = NR+N;

  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0;
  logic [WL-1:0] in_data = '0;
  logic in_last = 0;
  logic in_ready;
  logic [NR*WL-1:0] R_out;
  logic [N*WL-1:0] Y_out;
  logic frame_valid;
  logic frame_ack = 0;
  logic err_len;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  bit gap_mode = 0;
  logic [WL-1:0] mr [N][N];
  logic [WL-1:0] my [N];
  logic [WL-1:0] stream [$];

  channel_frame_loader #(.WL(WL), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .R_out(R_out), .Y_out(Y_out), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .err_len(err_len), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic logic [NR*WL-1:0] exp_r();
    logic [NR*WL-1:0] v = '0;
    for (int i = 0; i < N; i++)
      for (int j = i; j < N; j++)
        v[(i*N - i*(i-1)/2 + (j-i))*WL +: WL] = mr[i][j];
    return v;
  endfunction

  function automatic logic [N*WL-1:0] exp_y();
    logic [N*WL-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i*WL +: WL] = my[i];
    return v;
  endfunction

  task automatic build_frame(input bit pattern);
    stream.delete();
    for (int i = 0; i < N; i++) begin
      my[i] = pattern ? WL'(200 + i) : WL'($urandom);
      for (int j = 0; j < N; j++) mr[i][j] = pattern ? WL'(16*i + j) : WL'($urandom);
    end
    for (int i = 0; i < N; i++)
      for (int j = i; j < N; j++) stream.push_back(mr[i][j]);
    for (int i = 0; i < N; i++) stream.push_back(my[i]);
  endtask

  task automatic push(input logic [WL-1:0] d, input logic l);
    int g = 0;
    if (gap_mode) begin
      in_valid = 0;
      frame_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      frame_ack = 0;
    end
    in_valid = 1; in_data = d; in_last = l;
    while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL push_ready: in_ready=%0b after %0d cycles, required 1", in_ready, g);
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic do_ack();
    frame_ack = 1;
    @(posedge clk); #1;
    frame_ack = 0;
  endtask

  task automatic send_good(input string tag);
    for (int w = 0; w < NW-1; w++) push(stream[w], 0);
    n_checks++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL %s early_fv: got %0b, required 0", tag, frame_valid); end
    push(stream[NW-1], 1);
    exp_cnt = (exp_cnt + 1) % 256;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({in_ready, frame_valid, err_len} !== 3'b0 || frame_cnt !== 8'd0 || R_out !== '0 || Y_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%0b fv=%0b err=%0b cnt=%0d R=%0h Y=%0h, required all 0",
               in_ready, frame_valid, err_len, frame_cnt, R_out, Y_out);
    end
    #9 rst = 1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_rdy: got %0b, required 0", in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_edge_rdy: got %0b, required 1", in_ready); end
  endtask

  task automatic test_single();
    gap_mode = 0;
    build_frame(1);
    send_good("single");
    n_checks++;
    if (frame_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_fv: fv=%0b rdy=%0b, required fv=1 rdy=0", frame_valid, in_ready);
    end
    n_checks++;
    if (R_out !== exp_r()) begin n_fail++; $display("FAIL single_R: got %0h, required %0h", R_out, exp_r()); end
    n_checks++;
    if (Y_out !== exp_y()) begin n_fail++; $display("FAIL single_Y: got %0h, required %0h", Y_out, exp_y()); end
    n_checks++;
    if (R_out[8*WL +: WL] !== 16'd17 || R_out[35*WL +: WL] !== 16'd119 || Y_out[7*WL +: WL] !== 16'd207) begin
      n_fail++;
      $display("FAIL single_spot: R8=%0d R35=%0d Y7=%0d, required 17 119 207",
               R_out[8*WL +: WL], R_out[35*WL +: WL], Y_out[7*WL +: WL]);
    end
    n_checks++;
    if (frame_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL single_cnt: got %0d, required %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_back_pressure();
    logic [NR*WL-1:0] r0 = R_out;
    logic [N*WL-1:0] y0 = Y_out;
    logic [NR*WL-1:0] r_old = exp_r();
    logic [N*WL-1:0] y_old = exp_y();
    build_frame(0);
    in_valid = 1; in_data = stream[0]; in_last = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b0 || frame_valid !== 1'b1 || R_out !== r_old || Y_out !== y_old) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: rdy=%0b fv=%0b held=%0b, required rdy=0 fv=1 held=1",
                 c, in_ready, frame_valid, R_out === r0 && Y_out === y0);
      end
    end
    do_ack();
    n_checks++;
    if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ack: fv=%0b rdy=%0b, required fv=0 rdy=1", frame_valid, in_ready);
    end
    send_good("bp");
    n_checks++;
    if (frame_valid !== 1'b1 || R_out !== exp_r() || Y_out !== exp_y()) begin
      n_fail++; $display("FAIL bp_frame2: fv=%0b R=%0h Y=%0h, required 1 %0h %0h", frame_valid, R_out, Y_out, exp_r(), exp_y());
    end
    n_checks++;
    if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_cnt: got %0d, required 2", frame_cnt); end
    do_ack();
  endtask

  task automatic test_gapped();
    gap_mode = 1;
    build_frame(1);
    send_good("gap");
    gap_mode = 0;
    n_checks++;
    if (frame_valid !== 1'b1 || R_out !== exp_r() || Y_out !== exp_y() || frame_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL gap_frame: fv=%0b cnt=%0d R=%0h Y=%0h, required 1 %0d %0h %0h",
               frame_valid, frame_cnt, R_out, Y_out, exp_cnt, exp_r(), exp_y());
    end
    do_ack();
  endtask

  task automatic test_len_err(input string tag, input int nwords, input bit last_at_end);
    build_frame(0);
    for (int w = 0; w < nwords-1; w++) push(stream[w], 0);
    push(stream[nwords-1], last_at_end);
    n_checks++;
    if (err_len !== 1'b1 || frame_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_err: err=%0b fv=%0b rdy=%0b, required 1 0 1", tag, err_len, frame_valid, in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (err_len !== 1'b0 || frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_pulse: err=%0b fv=%0b, required 0 0", tag, err_len, frame_valid);
    end
    build_frame(0);
    send_good(tag);
    n_checks++;
    if (frame_valid !== 1'b1 || R_out !== exp_r() || Y_out !== exp_y() || frame_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL %s_recover: fv=%0b cnt=%0d R=%0h Y=%0h, required 1 %0d %0h %0h",
               tag, frame_valid, frame_cnt, R_out, Y_out, exp_cnt, exp_r(), exp_y());
    end
    do_ack();
  endtask

  task automatic test_async_reset();
    build_frame(0);
    for (int w = 0; w <= 30; w++) push(stream[w], 0);
    in_valid = 1; in_data = stream[31];
    #2 rst = 0;
    #1;
    n_checks++;
    if ({in_ready, frame_valid, err_len} !== 3'b0 || frame_cnt !== 8'd0 || R_out !== '0 || Y_out !== '0) begin
      n_fail++;
      $display("FAIL areset_outputs: rdy=%0b fv=%0b err=%0b cnt=%0d R=%0h Y=%0h, required all 0",
               in_ready, frame_valid, err_len, frame_cnt, R_out, Y_out);
    end
    #2 rst = 1;
    in_valid = 0;
    exp_cnt = 0;
    @(posedge clk); #1;
    build_frame(0);
    send_good("areset");
    n_checks++;
    if (frame_valid !== 1'b1 || R_out !== exp_r() || Y_out !== exp_y() || frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL areset_frame: fv=%0b cnt=%0d R=%0h Y=%0h, required 1 1 %0h %0h",
               frame_valid, frame_cnt, R_out, Y_out, exp_r(), exp_y());
    end
    do_ack();
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      gap_mode = 1'($urandom_range(0, 1));
      build_frame(0);
      send_good("rand");
      gap_mode = 0;
      n_checks++;
      if (frame_valid !== 1'b1 || R_out !== exp_r() || Y_out !== exp_y() || frame_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL rand_frame%0d: fv=%0b cnt=%0d R=%0h Y=%0h, required 1 %0d %0h %0h",
                 f, frame_valid, frame_cnt, R_out, Y_out, exp_cnt, exp_r(), exp_y());
      end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_gapped();
    test_len_err("short", 21, 1'b1);
    test_len_err("long", NW, 1'b0);
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
